// File: rtl/enc_16x4_seq.sv
// enc_16x4_seq: sequential 16-to-4 index encoder.
//
// A request vector is captured on the input handshake. Its set bits are then
// emitted as binary indices, lowest index first, one per output handshake.
// When the final index is taken the block returns to IDLE and accepts the
// next vector. The two handshakes never overlap, so consecutive vectors are
// separated by one cycle with no out_valid.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised, the data and
// valid stay stable until that transfer. out_* and in_ready come only from
// registered state and never depend combinationally on out_ready or in_valid.
//
// N must equal 2**IDX_W.

module enc_16x4_seq #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W:0]   pend_cnt,
    output logic             err_empty
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d;
    logic             err_empty_q, err_empty_d;

    // Combinational views of the pending vector.
    logic [IDX_W-1:0] low_idx;
    logic [IDX_W:0]   pop;
    logic             single_bit;
    logic             in_fire;
    logic             out_fire;

    // Lowest set bit of pend_q. Scan from the top down so that the last
    // match, which is the lowest bit, wins. The result is 0 when pend_q is 0.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Population count of pend_q. It needs IDX_W+1 bits to hold N.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + (IDX_W + 1)'(pend_q[i]);
        end
    end

    // Exactly one bit is set when the vector is nonzero and clearing its
    // lowest set bit leaves zero.
    always_comb begin
        single_bit = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
    end

    // Port outputs. All of them decode from registered state only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_EMIT);
        out_idx   = (state_q == ST_EMIT) ? low_idx : '0;
        out_last  = (state_q == ST_EMIT) ? single_bit : 1'b0;
        pend_cnt  = (state_q == ST_EMIT) ? pop : '0;
        err_empty = err_empty_q;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Next-state logic. The defaults hold all state and clear the empty flag,
    // which makes err_empty a one-cycle pulse.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        err_empty_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_vec != '0) begin
                        pend_d  = in_vec;
                        state_d = ST_EMIT;
                    end else begin
                        err_empty_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    // Clear the bit that was just emitted. When it was the
                    // last bit, pend becomes zero and pend_cnt reads 0 in IDLE.
                    pend_d[low_idx] = 1'b0;
                    if (single_bit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // State registers. Reset is asynchronous, so a reset during EMIT drops
    // out_valid at once and discards the pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            err_empty_q <= err_empty_d;
        end
    end

endmodule

// File: tb/tb_enc_16x4_seq.sv
// Directed testbench for enc_16x4_seq. Inputs are driven and outputs are
// sampled on the falling clock edge, away from the active rising edge.

module tb_enc_16x4_seq;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic [IDX_W:0]   pend_cnt;
    logic             err_empty;

    int errors = 0;
    int checks = 0;

    enc_16x4_seq #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .pend_cnt  (pend_cnt),
        .err_empty (err_empty)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // The block is idle: ready for input and emitting nothing.
    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_idx"},   32'(out_idx),   32'd0);
        check({tag, ".out_last"},  32'(out_last),  32'd0);
        check({tag, ".pend_cnt"},  32'(pend_cnt),  32'd0);
    endtask

    // Check that the current beat is valid, then advance one cycle.
    task automatic beat(input string tag, input int idx, input bit last, input int cnt);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".out_idx"},   32'(out_idx),   32'(idx));
        check({tag, ".out_last"},  32'(out_last),  32'(last));
        check({tag, ".pend_cnt"},  32'(pend_cnt),  32'(cnt));
        @(negedge clk);
    endtask

    // Offer one vector for a single cycle. The block must be ready for it.
    task automatic send(input string tag, input logic [N-1:0] vec);
        check({tag, ".send_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_vec   = vec;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;

        // Reset state. Inputs are active while reset is asserted and must be ignored.
        in_valid = 1'b1;
        in_vec   = 16'h00FF;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset.err_empty", 32'(err_empty), 32'd0);
        in_valid = 1'b0;
        in_vec   = '0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Single bit.
        send("single", 16'h0001);
        beat("single.b0", 0, 1'b1, 1);
        check_idle("single.done");

        // Sparse vector.
        send("sparse", 16'h8421);
        beat("sparse.b0", 0,  1'b0, 4);
        beat("sparse.b1", 5,  1'b0, 3);
        beat("sparse.b2", 10, 1'b0, 2);
        beat("sparse.b3", 15, 1'b1, 1);
        check_idle("sparse.done");

        // Empty vector: err_empty pulses for one cycle and nothing is emitted.
        send("empty", 16'h0000);
        check("empty.err_hi", 32'(err_empty), 32'd1);
        check_idle("empty.hi");
        @(negedge clk);
        check("empty.err_lo", 32'(err_empty), 32'd0);
        check_idle("empty.lo");

        // Full vector with alternating backpressure.
        out_ready = 1'b0;
        send("full", 16'hFFFF);
        for (int i = 0; i < N; i++) begin
            out_ready = 1'b0;
            check($sformatf("full.stall%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("full.stall%0d.out_idx", i),   32'(out_idx),   32'(i));
            check($sformatf("full.stall%0d.out_last", i),  32'(out_last),  32'(i == N - 1));
            check($sformatf("full.stall%0d.pend_cnt", i),  32'(pend_cnt),  32'(N - i));
            @(negedge clk);
            out_ready = 1'b1;
            beat($sformatf("full.b%0d", i), i, (i == N - 1), N - i);
        end
        check_idle("full.done");

        // Reset in the middle of EMIT.
        send("rst_mid", 16'h00F0);
        beat("rst_mid.b0", 4, 1'b0, 4);
        beat("rst_mid.b1", 5, 1'b0, 3);
        check("rst_mid.pre_valid", 32'(out_valid), 32'd1);
        check("rst_mid.pre_idx",   32'(out_idx),   32'd6);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid.async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_mid.release");
        send("rst_mid.next", 16'h0002);
        beat("rst_mid.next.b0", 1, 1'b1, 1);
        check_idle("rst_mid.next.done");

        // Back-to-back vectors with in_valid held high.
        in_valid = 1'b1;
        in_vec   = 16'h0003;
        @(negedge clk);
        in_vec   = 16'h0100;
        beat("b2b.a0", 0, 1'b0, 2);
        beat("b2b.a1", 1, 1'b1, 1);
        check_idle("b2b.gap");
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = '0;
        beat("b2b.b0", 8, 1'b1, 1);
        check_idle("b2b.done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit, in case the main sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
